rs_fifo_rd_arbiter: RTL and testbench
=====================================

Name: rs_fifo_rd_arbiter

Overview:
Read-side scheduler that shares one downstream consumer among NUM_CH rs_async_fifo_afe read ports, all clocked by the same rclk. It picks a channel round-robin each cycle and drives that channel's rd pop strobe. It captures the show-ahead rd_data into a registered valid/ready output stage. It also enforces the one-cycle post-pop hold-off needed because the FIFO's empty flag is registered and lags a pop by one cycle.

Parameters:
NUM_CH, 4, number of FIFO read ports arbitrated (2..16)
DATASIZE, 32, data width of each FIFO and of out_data
CH_W, $clog2(NUM_CH), localparam, width of channel index

Ports:
rclk  in  1  read-domain clock, shared by all arbitrated FIFOs
rd_rst  in  1  asynchronous, active-high reset
ch_empty  in  NUM_CH  per-channel FIFO empty (bit i = channel i)
ch_rd_data  in  NUM_CH*DATASIZE  per-channel show-ahead read data, channel i at [i*DATASIZE +: DATASIZE]
ch_rd  out  NUM_CH  per-channel pop strobe, at most one bit set
ch_enable  in  NUM_CH  per-channel arbitration enable mask
out_valid  out  1  output register holds a word
out_ready  in  1  consumer accepts word this cycle
out_data  out  DATASIZE  registered word
out_ch  out  CH_W  source channel of out_data
busy  out  1  out_valid OR any channel eligible

Behaviour:
- Reset (rd_rst=1, async): out_valid=0, out_data=0, out_ch=0, holdoff=0, last_grant=NUM_CH-1. ch_rd is forced to 0 combinationally while rd_rst=1.
- Eligibility: elig[i] = ch_enable[i] & ~ch_empty[i] & ~holdoff[i].
- Load condition: load = (~out_valid | out_ready) & |elig.
- Pick: round-robin over elig, starting at (last_grant+1) mod NUM_CH and wrapping. Search is purely combinational.
- Grant: ch_rd[g] = load, combinational, same cycle. On the rclk edge:
  - out_data <= ch_rd_data[g]
  - out_ch <= g
  - out_valid <= 1
  - last_grant <= g
- Not loading: if out_valid & out_ready, then out_valid <= 0 and out_data/out_ch are held. If ~out_ready, all output registers are held stable.
- Hold-off: each cycle, holdoff <= onehot(g) when load, else 0. A channel is never popped in two consecutive cycles, because its empty flag is stale for one cycle after a pop.
- Throughput: a single active channel gets one word per 2 cycles. With two or more eligible channels, one word per cycle is sustained.
- Latency: data visible on ch_rd_data with ch_empty=0 appears on out_data one cycle later (registered), given out_ready=1.
- Wrap: last_grant=NUM_CH-1 makes the search start at channel 0.
- ch_enable deassert: takes effect on the next pick. A word already in the output register still drains.
- Simultaneous events: pop of a new word and acceptance of the old word in the same cycle is allowed (full-rate pipe).
- Reset mid-operation: any in-flight out_valid word is discarded. The FIFOs are reset separately by their own domain resets.
- Widths: all index arithmetic is modulo NUM_CH. Non-power-of-2 NUM_CH wraps explicitly, not by truncation.

Decomposition:
- Package rs_fifo_arb_pkg holds:
  - CH_W helper function (clog2 with minimum 1)
  - rotate-left/rotate-right helper functions for the round-robin mask
- Sub-module rs_rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_CH], last[CH_W].
  - Outputs: gnt_onehot, gnt_idx, any.
  - Reused later by the write-side distributor.

Test Plan:
1. rd_rst=1 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 and ch_rd=0 immediately (before the next edge). After release, the first grant goes to ch0 if it is eligible.
2. Only ch1 non-empty with words 0xA1,0xA2,0xA3, out_ready=1 -> ch_rd=4'b0010 on cycles 0,2,4 only. out_data = 0xA1,0xA2,0xA3 with out_ch=1, and out_valid shows 1,0,1,0,1.
3. All 4 channels non-empty, out_ready=1 -> ch_rd sequence 0001,0010,0100,1000,0001 on consecutive cycles. out_ch = 0,1,2,3,0 and out_valid stays 1 continuously.
4. out_valid=1 with out_data=0x55, out_ready held 0 for 5 cycles -> ch_rd=0 and out_data=0x55 stable throughout. Raising out_ready -> the next word is loaded in the same cycle.
5. ch_enable=4'b1011, all channels non-empty -> ch2 is never granted; grant order is 0,1,3,0,1,3.
6. Only ch3 has 1 word, with ch_empty held low for one stale cycle after the pop -> exactly one pop. No second ch_rd[3] assertion occurs during the hold-off cycle.

Source files
------------

// File: rtl/rs_fifo_arb_pkg.sv
// Shared helpers for the rs FIFO arbiters: channel-index width and the
// rotations used to turn a round-robin search into a fixed-priority one.
package rs_fifo_arb_pkg;

  localparam int MAX_CH = 16;

  // Index width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // r[i] = v[(i + sh) mod n] for i < n; bits at or above n are zero.
  function automatic logic [MAX_CH-1:0] rot_right(input logic [MAX_CH-1:0] v,
                                                  input logic [3:0] sh,
                                                  input int n);
    logic [MAX_CH-1:0] r;
    int unsigned j;
    r = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      for (int s = 0; s < MAX_CH; s++) begin
        if (i < n && s < n && sh == s[3:0]) begin
          j = unsigned'((i + s) % n);
          r[i] = v[j[3:0]];
        end
      end
    end
    return r;
  endfunction

  // Inverse of rot_right: r[(i + sh) mod n] = v[i] for i < n.
  function automatic logic [MAX_CH-1:0] rot_left(input logic [MAX_CH-1:0] v,
                                                 input logic [3:0] sh,
                                                 input int n);
    logic [MAX_CH-1:0] r;
    int unsigned j;
    r = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      for (int s = 0; s < MAX_CH; s++) begin
        if (i < n && s < n && sh == s[3:0]) begin
          j = unsigned'((i + s) % n);
          r[j[3:0]] = v[i];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after
// (last + 1) mod NUM_CH, wrapping explicitly for non-power-of-2 counts.
module rs_rr_pick
  import rs_fifo_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   last,
  output logic [NUM_CH-1:0] gnt_onehot,
  output logic [CH_W-1:0]   gnt_idx,
  output logic              any
);

  logic [MAX_CH-1:0] req_pad;
  logic [MAX_CH-1:0] req_rot;
  int                start;
  int                k_sel;
  int                sum;

  always_comb begin
    req_pad = '0;
    req_pad[NUM_CH-1:0] = req;
    start = (int'(last) >= NUM_CH - 1) ? 0 : int'(last) + 1;
    // After rotation, bit 0 is the highest-priority channel.
    req_rot = rot_right(req_pad, 4'(start), NUM_CH);
    any = |req_rot;

    k_sel = 0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_rot[k]) k_sel = k;
    end

    sum = start + k_sel;
    if (sum >= NUM_CH) sum = sum - NUM_CH;
    gnt_idx = any ? CH_W'(sum) : '0;

    gnt_onehot = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (any && sum == i) gnt_onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/rs_fifo_rd_arbiter.sv
// Round-robin read scheduler over NUM_CH show-ahead FIFOs feeding one
// registered valid/ready output stage.
module rs_fifo_rd_arbiter
  import rs_fifo_arb_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATASIZE = 32,
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic                       rclk,
  input  logic                       rd_rst,
  input  logic [NUM_CH-1:0]          ch_empty,
  input  logic [NUM_CH*DATASIZE-1:0] ch_rd_data,
  output logic [NUM_CH-1:0]          ch_rd,
  input  logic [NUM_CH-1:0]          ch_enable,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATASIZE-1:0]        out_data,
  output logic [CH_W-1:0]            out_ch,
  output logic                       busy
);

  logic [NUM_CH-1:0]   holdoff_reg;
  logic [CH_W-1:0]     last_grant_reg;
  logic                out_valid_reg;
  logic [DATASIZE-1:0] out_data_reg;
  logic [CH_W-1:0]     out_ch_reg;

  logic [NUM_CH-1:0]   elig;
  logic [NUM_CH-1:0]   gnt_onehot;
  logic [CH_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic                load;
  logic [DATASIZE-1:0] ch_word [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_word
      assign ch_word[gi] = ch_rd_data[gi*DATASIZE +: DATASIZE];
    end
  endgenerate

  // The empty flag lags a pop by a cycle, so the channel just popped sits out one pick.
  assign elig = ch_enable & ~ch_empty & ~holdoff_reg;

  rs_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req        (elig),
    .last       (last_grant_reg),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (gnt_any)
  );

  assign load  = (~out_valid_reg | out_ready) & gnt_any;
  assign ch_rd = (load && !rd_rst) ? gnt_onehot : '0;
  assign busy  = out_valid_reg | (|elig);

  always_ff @(posedge rclk or posedge rd_rst) begin
    if (rd_rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_ch_reg     <= '0;
      holdoff_reg    <= '0;
      last_grant_reg <= CH_W'(NUM_CH - 1);
    end else begin
      holdoff_reg <= load ? gnt_onehot : '0;
      if (load) begin
        out_valid_reg  <= 1'b1;
        out_data_reg   <= ch_word[gnt_idx];
        out_ch_reg     <= gnt_idx;
        last_grant_reg <= gnt_idx;
      end else if (out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_rs_fifo_rd_arbiter.sv
// Directed bench for rs_fifo_rd_arbiter with NUM_CH=4, DATASIZE=32.
module tb_rs_fifo_rd_arbiter;

  logic         rclk = 1'b0;
  logic         rd_rst = 1'b1;
  logic [3:0]   ch_empty = 4'b1111;
  logic [127:0] ch_rd_data = '0;
  logic [3:0]   ch_rd;
  logic [3:0]   ch_enable = 4'b1111;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_data;
  logic [1:0]   out_ch;
  logic         busy;

  int tests = 0;
  int fails = 0;

  rs_fifo_rd_arbiter #(.NUM_CH(4), .DATASIZE(32)) dut (
    .rclk       (rclk),
    .rd_rst     (rd_rst),
    .ch_empty   (ch_empty),
    .ch_rd_data (ch_rd_data),
    .ch_rd      (ch_rd),
    .ch_enable  (ch_enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .busy       (busy)
  );

  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int ch, input logic [31:0] val);
    ch_rd_data[ch*32 +: 32] = val;
  endtask

  logic [3:0]  rd2  [5] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0010};
  logic        v2   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] din2 [5] = '{32'hA1, 32'hA2, 32'hA2, 32'hA3, 32'hA3};
  logic [31:0] dq2  [5] = '{32'hA1, 32'hA1, 32'hA2, 32'hA2, 32'hA3};
  logic [3:0]  rd3  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [1:0]  ch3  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0]  rd5  [6] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
  logic [1:0]  ch5  [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

  initial begin
    // Power-on reset state
    repeat (2) @(posedge rclk);
    @(negedge rclk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_rd", 32'(ch_rd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rd_rst = 1'b0;
    $display("[TB] reset state checked");

    // Single active channel: one word every other cycle
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      ch_empty = 4'b1101;
      set_data(1, din2[i]);
      #1;
      chk($sformatf("t2_rd_c%0d", i), 32'(ch_rd), 32'(rd2[i]));
      @(posedge rclk); #1;
      chk($sformatf("t2_valid_c%0d", i), 32'(out_valid), 32'(v2[i]));
      chk($sformatf("t2_data_c%0d", i), out_data, dq2[i]);
      chk($sformatf("t2_ch_c%0d", i), 32'(out_ch), 32'd1);
    end
    $display("[TB] single channel A1/A2/A3 sequence checked");

    // Mid-stream reset with a word held and all channels eligible
    @(negedge rclk);
    chk("t1_pre_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 4; c++) set_data(c, 32'hC0 + 32'(c));
    ch_empty = 4'b0000;
    rd_rst = 1'b1;
    #1;
    chk("t1_async_valid", 32'(out_valid), 32'd0);
    chk("t1_async_data", out_data, 32'd0);
    chk("t1_async_ch", 32'(out_ch), 32'd0);
    chk("t1_async_rd", 32'(ch_rd), 32'd0);
    @(posedge rclk);
    $display("[TB] mid-stream reset checked");

    // All channels non-empty: full-rate rotation starting at ch0
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      rd_rst = 1'b0;
      #1;
      chk($sformatf("t3_rd_c%0d", i), 32'(ch_rd), 32'(rd3[i]));
      @(posedge rclk); #1;
      chk($sformatf("t3_valid_c%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("t3_ch_c%0d", i), 32'(out_ch), 32'(ch3[i]));
      chk($sformatf("t3_data_c%0d", i), out_data, 32'hC0 + 32'(ch3[i]));
    end
    $display("[TB] four-channel rotation checked");

    // Back-pressure: 0x55 held while out_ready is low
    @(negedge rclk);
    ch_empty = 4'b1101;
    set_data(1, 32'h55);
    #1;
    chk("t4_load_rd", 32'(ch_rd), 32'b0010);
    @(posedge rclk); #1;
    chk("t4_load_data", out_data, 32'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge rclk);
      out_ready = 1'b0;
      ch_empty = 4'b0000;
      set_data(2, 32'h66);
      #1;
      chk($sformatf("t4_stall_rd_c%0d", i), 32'(ch_rd), 32'd0);
      chk($sformatf("t4_stall_busy_c%0d", i), 32'(busy), 32'd1);
      @(posedge rclk); #1;
      chk($sformatf("t4_stall_data_c%0d", i), out_data, 32'h55);
      chk($sformatf("t4_stall_valid_c%0d", i), 32'(out_valid), 32'd1);
    end
    @(negedge rclk);
    out_ready = 1'b1;
    #1;
    chk("t4_resume_rd", 32'(ch_rd), 32'b0100);
    @(posedge rclk); #1;
    chk("t4_resume_data", out_data, 32'h66);
    chk("t4_resume_ch", 32'(out_ch), 32'd2);
    $display("[TB] back-pressure stall and resume checked");

    // Enable mask 1011: ch2 skipped
    @(negedge rclk);
    ch_empty = 4'b1111;
    rd_rst = 1'b1;
    @(negedge rclk);
    rd_rst = 1'b0;
    ch_enable = 4'b1011;
    ch_empty = 4'b0000;
    set_data(2, 32'hC2);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge rclk);
      #1;
      chk($sformatf("t5_rd_c%0d", i), 32'(ch_rd), 32'(rd5[i]));
      @(posedge rclk); #1;
      chk($sformatf("t5_ch_c%0d", i), 32'(out_ch), 32'(ch5[i]));
    end
    $display("[TB] enable mask order checked");

    // Single word in ch3 with one stale not-empty cycle after the pop
    @(negedge rclk);
    ch_enable = 4'b1111;
    ch_empty = 4'b1111;
    @(negedge rclk);
    ch_empty = 4'b0111;
    set_data(3, 32'hD3);
    #1;
    chk("t6_pop_rd", 32'(ch_rd), 32'b1000);
    @(posedge rclk); #1;
    chk("t6_pop_data", out_data, 32'hD3);
    chk("t6_pop_ch", 32'(out_ch), 32'd3);
    @(negedge rclk);
    #1;
    chk("t6_stale_rd", 32'(ch_rd), 32'd0);
    @(posedge rclk); #1;
    chk("t6_stale_valid", 32'(out_valid), 32'd0);
    @(negedge rclk);
    ch_empty = 4'b1111;
    #1;
    chk("t6_idle_rd", 32'(ch_rd), 32'd0);
    chk("t6_idle_busy", 32'(busy), 32'd0);
    $display("[TB] hold-off single pop checked");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
